// File: rtl/airi5c_float_cmp_ctrl_pkg.sv
// Shared FPU definitions for the compare/min/max path:
// op encodings, canonical NaN and controller state encoding.
package airi5c_float_cmp_ctrl_pkg;

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/airi5c_float_comparator_comb.sv
// Combinational IEEE-754 single compare: ordering flags,
// NaN/sNaN/zero classification; +0 and -0 compare equal.
module airi5c_float_comparator_comb (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        less,
  output logic        equal,
  output logic        greater,
  output logic        unordered,
  output logic        nan_a,
  output logic        nan_b,
  output logic        snan_a,
  output logic        snan_b,
  output logic        zero_a,
  output logic        zero_b
);

  logic mag_lt;

  assign nan_a = (&a[30:23]) & (|a[22:0]);
  assign nan_b = (&b[30:23]) & (|b[22:0]);
  assign snan_a = nan_a & ~a[22];
  assign snan_b = nan_b & ~b[22];
  assign zero_a = (a[30:0] == 31'd0);
  assign zero_b = (b[30:0] == 31'd0);
  assign unordered = nan_a | nan_b;
  assign mag_lt = (a[30:0] < b[30:0]);

  always_comb begin
    less    = 1'b0;
    equal   = 1'b0;
    greater = 1'b0;
    if (unordered) begin
      equal = 1'b0;
    end else if ((zero_a & zero_b) | (a == b)) begin
      equal = 1'b1;
    end else if (a[31] != b[31]) begin
      less    = a[31];
      greater = ~a[31];
    end else if (!a[31]) begin
      less    = mag_lt;
      greater = ~mag_lt;
    end else begin
      // both negative: larger magnitude is the smaller value
      less    = ~mag_lt;
      greater = mag_lt;
    end
  end

endmodule

// File: rtl/airi5c_float_cmp_ctrl.sv
// Sequencer for FEQ/FLT/FLE/FMIN/FMAX: registers operands,
// evaluates in one cycle and returns result/NV via load/ready.
module airi5c_float_cmp_ctrl
  import airi5c_float_cmp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic        load,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result,
  output logic        NV
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        accept;
  logic [31:0] res_d;
  logic        nv_d;

  logic less, equal, greater, unordered;
  logic nan_a, nan_b, snan_a, snan_b;
  logic zero_a, zero_b;

  airi5c_float_comparator_comb u_cmp (
    .a         (a_q),
    .b         (b_q),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .unordered (unordered),
    .nan_a     (nan_a),
    .nan_b     (nan_b),
    .snan_a    (snan_a),
    .snan_b    (snan_b),
    .zero_a    (zero_a),
    .zero_b    (zero_b)
  );

  assign accept = load & ~kill &
                  ((state == ST_IDLE) | (state == ST_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = accept ? ST_EVAL : ST_IDLE;
        ST_EVAL: state_nxt = ST_DONE;
        ST_DONE: state_nxt = accept ? ST_EVAL : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == ST_EVAL);
    ready = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 3'd0;
    end else if (accept) begin
      a_q  <= operand_a;
      b_q  <= operand_b;
      op_q <= op;
    end
  end

  always_comb begin
    res_d = 32'd0;
    nv_d  = 1'b0;
    unique case (1'b1)
      (op_q == OP_FEQ): begin
        res_d = {31'd0, equal};
        nv_d  = snan_a | snan_b;
      end
      (op_q == OP_FLT): begin
        res_d = {31'd0, less};
        nv_d  = unordered;
      end
      (op_q == OP_FLE): begin
        res_d = {31'd0, less | equal};
        nv_d  = unordered;
      end
      (op_q == OP_FMIN),
      (op_q == OP_FMAX): begin
        nv_d = snan_a | snan_b;
        if (nan_a & nan_b) begin
          res_d = CANON_NAN;
        end else if (nan_a) begin
          res_d = b_q;
        end else if (nan_b) begin
          res_d = a_q;
        end else if (zero_a & zero_b) begin
          // comparator says equal for +-0; pick by sign bit
          if (op_q == OP_FMIN) begin
            res_d = a_q[31] ? a_q : b_q;
          end else begin
            res_d = a_q[31] ? b_q : a_q;
          end
        end else if (op_q == OP_FMIN) begin
          res_d = (less | equal) ? a_q : b_q;
        end else begin
          res_d = (greater | equal) ? a_q : b_q;
        end
      end
      default: begin
        res_d = 32'd0;
        nv_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= 32'd0;
      NV     <= 1'b0;
    end else if ((state == ST_EVAL) && !kill) begin
      result <= res_d;
      NV     <= nv_d;
    end
  end

endmodule

// File: tb/tb_airi5c_float_cmp_ctrl.sv
// Directed + randomized bench for airi5c_float_cmp_ctrl with an
// ordered-key reference model of the compare/min/max rules.
module tb_airi5c_float_cmp_ctrl;

  logic        clk;
  logic        reset;
  logic        kill;
  logic        load;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        ready;
  logic [31:0] result;
  logic        NV;

  int checks = 0;
  int errors = 0;

  airi5c_float_cmp_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .load      (load),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .ready     (ready),
    .result    (result),
    .NV        (NV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Total-order key of a non-NaN float; -0 and +0 both map to 0.
  function automatic longint fkey(logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  // Returns {NV, result}.
  function automatic logic [32:0] ref_model(logic [2:0] o,
                                            logic [31:0] a,
                                            logic [31:0] b);
    bit na, nb, un, sn;
    longint ka, kb;
    logic [31:0] r;
    logic v;
    na = is_nan(a);
    nb = is_nan(b);
    un = na || nb;
    sn = (na && !a[22]) || (nb && !b[22]);
    ka = fkey(a);
    kb = fkey(b);
    r = 32'd0;
    v = 1'b0;
    case (o)
      3'd0: begin r = {31'd0, (!un && ka == kb)}; v = sn; end
      3'd1: begin r = {31'd0, (!un && ka < kb)};  v = un; end
      3'd2: begin r = {31'd0, (!un && ka <= kb)}; v = un; end
      3'd3, 3'd4: begin
        v = sn;
        if (na && nb) r = 32'h7FC00000;
        else if (na) r = b;
        else if (nb) r = a;
        else if (ka != kb) begin
          if (o == 3'd3) r = (ka < kb) ? a : b;
          else           r = (ka > kb) ? a : b;
        end else if (ka == 0) begin
          if (o == 3'd3) r = (a[31] | b[31]) ? 32'h80000000 : 32'h0;
          else           r = (a[31] & b[31]) ? 32'h80000000 : 32'h0;
        end else r = a;
      end
      default: begin r = 32'd0; v = 1'b0; end
    endcase
    return {v, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts with load asserted now (state IDLE or DONE); ends in DONE.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [32:0] e;
    e = ref_model(o, a, b);
    op = o;
    operand_a = a;
    operand_b = b;
    load = 1'b1;
    step();
    load = 1'b0;
    op = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    chk({tag, " busy_eval"}, {31'd0, busy}, 32'd1);
    chk({tag, " ready_eval"}, {31'd0, ready}, 32'd0);
    step();
    chk({tag, " ready"}, {31'd0, ready}, 32'd1);
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, e[31:0]);
    chk({tag, " nv"}, {31'd0, NV}, {31'd0, e[32]});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] pool [13];
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
             32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
             32'h7F800001, 32'hFFC00000, 32'h00000001, 32'h80000001,
             32'h7F7FFFFF};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 12)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra, rb, held;
    logic [2:0]  ro;
    reset = 1'b0;
    kill = 1'b0;
    load = 1'b0;
    op = 3'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    #2 reset = 1'b1;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ready", {31'd0, ready}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst nv", {31'd0, NV}, 32'd0);
    step();
    reset = 1'b0;
    step();

    do_op(3'd1, 32'h3F800000, 32'h40000000, "flt_1_2");
    step();
    chk("flt idle ready", {31'd0, ready}, 32'd0);
    chk("flt idle busy", {31'd0, busy}, 32'd0);

    do_op(3'd0, 32'h7F800001, 32'h3F800000, "feq_snan");
    step();
    do_op(3'd0, 32'h7FC00000, 32'h3F800000, "feq_qnan");
    step();
    do_op(3'd1, 32'h7FC00000, 32'h3F800000, "flt_qnan");
    step();
    do_op(3'd3, 32'h00000000, 32'h80000000, "fmin_zero");
    step();
    do_op(3'd4, 32'h00000000, 32'h80000000, "fmax_zero");
    step();
    do_op(3'd4, 32'h7FC00000, 32'h40400000, "fmax_qnan");
    step();
    do_op(3'd3, 32'h7F800001, 32'h7FC00000, "fmin_snan_qnan");
    step();

    do_op(3'd2, 32'h40000000, 32'h40000000, "b2b_fle");
    do_op(3'd3, 32'hC0000000, 32'h40000000, "b2b_fmin");
    step();

    // load held through EVAL must be taken only once
    op = 3'd1;
    operand_a = 32'hBF800000;
    operand_b = 32'h3F800000;
    load = 1'b1;
    step();
    chk("hold busy", {31'd0, busy}, 32'd1);
    step();
    load = 1'b0;
    chk("hold ready", {31'd0, ready}, 32'd1);
    chk("hold result", result, 32'd1);
    step();
    chk("hold once ready", {31'd0, ready}, 32'd0);
    chk("hold once busy", {31'd0, busy}, 32'd0);

    do_op(3'd6, 32'h3F800000, 32'h3F800000, "illegal");
    step();

    // kill during EVAL: result from the illegal op (0) must hold
    op = 3'd0;
    operand_a = 32'h3F800000;
    operand_b = 32'h3F800000;
    load = 1'b1;
    step();
    load = 1'b0;
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    chk("kill ready", {31'd0, ready}, 32'd0);
    chk("kill result", result, 32'd0);
    step();
    chk("kill ready2", {31'd0, ready}, 32'd0);

    kill = 1'b1;
    load = 1'b1;
    step();
    kill = 1'b0;
    load = 1'b0;
    chk("kill load busy", {31'd0, busy}, 32'd0);
    step();
    chk("kill load ready", {31'd0, ready}, 32'd0);

    do_op(3'd2, 32'h3F800000, 32'h40000000, "pre_rst");
    step();

    // async reset mid-op
    op = 3'd4;
    operand_a = 32'h40400000;
    operand_b = 32'h3F800000;
    load = 1'b1;
    step();
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst ready", {31'd0, ready}, 32'd0);
    chk("arst result", result, 32'd0);
    chk("arst nv", {31'd0, NV}, 32'd0);
    step();
    reset = 1'b0;
    step();
    do_op(3'd0, 32'h3F800000, 32'h3F800000, "post_rst_feq");
    step();

    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick_operand();
      held = ra;
      do_op(ro, held, rb, "rand");
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk("rand gap ready", {31'd0, ready}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/airi5c_float_cmp_ctrl.md
Name: airi5c_float_cmp_ctrl

Overview:
- Sequencing controller for the FPU compare/min/max path.
- Accepts one RISC-V F-extension compare-class operation per load, registers its operands and drives one instance of the combinational float comparator.
- Produces the architectural result plus the invalid-operation (NV) flag through a load/ready handshake.
- Sits beside the other multi-cycle FPU units under the FPU top; it shares the FPU's kill and result-mux conventions.

Parameters:
- CANON_NAN, 32'h7FC00000, canonical quiet NaN returned by FMIN/FMAX when both operands are NaN.

Ports:
- clk  in  1  FPU clock.
- reset  in  1  reset, asynchronous, active-high.
- kill  in  1  abort in-flight op; synchronous, has priority over load.
- load  in  1  start op; sampled only when busy=0.
- op  in  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX, 5..7 illegal.
- operand_a  in  32  IEEE-754 single operand rs1.
- operand_b  in  32  IEEE-754 single operand rs2.
- busy  out  1  op accepted and not yet delivered.
- ready  out  1  one-cycle pulse; result and NV valid in this cycle.
- result  out  32  FEQ/FLT/FLE: 0 or 1 zero-extended; FMIN/FMAX: selected float.
- NV  out  1  invalid-operation flag for this op.

Behaviour:
- Reset (async, reset=1): state=IDLE; busy=0, ready=0, result=0, NV=0; operand/op registers=0.
- States and transitions:
  - IDLE: on load=1 and kill=0, capture operand_a, operand_b and op into registers; next state EVAL.
  - EVAL: busy=1. Comparator inputs come from the registers only. Compute result/NV; register them at the clock edge; next state DONE.
  - DONE: ready=1, busy=0. A load in this cycle is accepted (back-to-back) and goes to EVAL. Otherwise go to IDLE.
- Latency: load sampled at edge N; ready=1 in cycle N+2. Throughput is one op per 2 cycles.
- Load while busy=1 is ignored; the requester holds load until busy=0.
- kill=1 in any state:
  - Next state IDLE; ready is not asserted for the aborted op.
  - result and NV keep their previous values.
  - A simultaneous load is dropped.
- result and NV hold after DONE until the next ready; ready is never asserted without a state transition through EVAL.
- FEQ:
  - result = equal.
  - NV = sNaN_a|sNaN_b.
  - Any NaN gives result 0.
- FLT:
  - result = less.
  - NV = unordered (any NaN, quiet or signalling).
- FLE:
  - result = less|equal.
  - NV = unordered.
- Signed zeros: +0 and -0 compare equal for FEQ/FLT/FLE (the comparator guarantees this).
- FMIN/FMAX:
  - NV = sNaN_a|sNaN_b.
  - Both operands NaN → CANON_NAN.
  - Exactly one NaN → the non-NaN operand, unmodified.
  - Otherwise FMIN picks a if less, else b; FMAX picks a if greater, else b.
  - Equal magnitude with zero operands: FMIN returns -0 if either operand is -0; FMAX returns +0 if either operand is +0. Decide from the raw sign bits, because the comparator reports equal for ±0.
  - Non-zero equal values return a.
- Illegal op: result=0, NV=0, ready still pulses; no hang.
- No other fflags are produced (NX/OF/UF/DZ are always 0 for this class).

Decomposition:
- Shared FPU package holds:
  - the op encodings (FEQ..FMAX, width 3);
  - CANON_NAN;
  - state encoding localparams (IDLE/EVAL/DONE).
- One sub-module instance: airi5c_float_comparator_comb (existing), fed from the operand registers.
- Result-select logic stays in this module as one combinational block registered in EVAL.

Test Plan:
- FLT a=0x3F800000 (1.0), b=0x40000000 (2.0), load at edge N → ready=1 at cycle N+2, result=1, NV=0; busy=1 only in cycle N+1.
- FEQ a=0x7F800001 (sNaN), b=0x3F800000 → result=0, NV=1. Repeat with qNaN 0x7FC00000 → result=0, NV=0. FLT with that qNaN → result=0, NV=1.
- FMIN a=0x00000000, b=0x80000000 → result=0x80000000. FMAX on the same operands → result=0x00000000. Both NV=0.
- FMAX a=0x7FC00000, b=0x40400000 → result=0x40400000, NV=0. FMIN a=0x7F800001, b=0x7FC00000 → result=0x7FC00000, NV=1.
- Back-to-back: load FLE (2.0, 2.0) then load in the DONE cycle → first ready result=1; second ready exactly 2 cycles later. A load held while busy is accepted exactly once.
- kill during EVAL → no ready pulse, busy=0 next cycle, result unchanged. Async reset asserted mid-op → all outputs 0 immediately; after release, a fresh FEQ (1.0, 1.0) returns result=1.
